// File: rtl/gcd_host_seq.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_host_seq
//  Description : Host-side sequencer for the subtractive GCD core. Accepts an
//                operand pair over valid/ready, serially loads the core
//                (start + A, start + B), waits for done, and returns result and
//                compute-cycle count over valid/ready. Zero operands bypass
//                the core.
//                Optional watchdog in WAIT: define GCD_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_host_seq #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [15:0]      res_cycles,
    output logic             res_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] b_hold;
    logic [15:0]      cyc_cnt;
    logic [15:0]      cyc_inc;
    logic             any_zero;
    logic             timeout_hit;

    // Saturating increment: a long-running core must not wrap the count.
    assign cyc_inc  = (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;
    assign any_zero = (op_a == '0) || (op_b == '0);

`ifdef GCD_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    logic err_q;

    // Watchdog fires on the WAIT cycle that would bring the count to the limit;
    // a done arriving on that same cycle still wins.
    assign timeout_hit = (cyc_inc == TIMEOUT_LIM);
    assign res_err     = err_q;

    // Error flag: set on watchdog expiry, cleared when the next pair is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == S_IDLE && op_valid) begin
            err_q <= 1'b0;
        end else if (state == S_WAIT && !gcd_done && timeout_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    // Without the watchdog the limit has no function; keep a sink for it.
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
    assign res_err            = 1'b0;
`endif

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; op_ready is high exactly in IDLE, so op_valid alone
    // marks an accept there.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (op_valid) state_nxt = any_zero ? S_RESP : S_LOAD_A;
            S_LOAD_A: state_nxt = S_LOAD_B;
            S_LOAD_B: state_nxt = S_WAIT;
            S_WAIT:   if (gcd_done || timeout_hit) state_nxt = S_RESP;
            S_RESP:   if (res_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Registered handshake/strobe outputs, decoded from the upcoming state so
    // they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_ready  <= 1'b1;
            gcd_start <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            op_ready  <= (state_nxt == S_IDLE);
            gcd_start <= (state_nxt == S_LOAD_A) || (state_nxt == S_LOAD_B);
            res_valid <= (state_nxt == S_RESP);
        end
    end

    // Datapath: operand capture, serial bus, cycle counter and result capture.
    // gcd_data doubles as the A holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_hold     <= '0;
            gcd_data   <= '0;
            cyc_cnt    <= '0;
            res_data   <= '0;
            res_cycles <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        b_hold  <= op_b;
                        cyc_cnt <= '0;
                        if (any_zero) begin
                            res_data   <= op_a | op_b;
                            res_cycles <= '0;
                        end else begin
                            gcd_data <= op_a;
                        end
                    end
                end
                S_LOAD_A: gcd_data <= b_hold;
                S_WAIT: begin
                    cyc_cnt <= cyc_inc;
                    if (gcd_done) begin
                        res_data   <= gcd_result;
                        res_cycles <= cyc_inc;
                    end else if (timeout_hit) begin
                        res_data   <= '0;
                        res_cycles <= cyc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_host_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_gcd_host_seq
//  Description : Self-checking bench for gcd_host_seq with a behavioural GCD
//                core, a cycle-level transaction model and directed plus
//                randomized transactions. Honours GCD_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_host_seq;

    localparam int W = 16;
`ifdef GCD_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          gcd_start;
    logic [W-1:0]  gcd_data;
    logic          gcd_done = 1'b0;
    logic [W-1:0]  gcd_result = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_data;
    logic [15:0]   res_cycles;
    logic          res_err;

    int n_checks = 0;
    int n_fail   = 0;
    int core_lat = 1;   // WAIT cycles the core takes; 0 = never finishes

    always #5 clk = ~clk;

    gcd_host_seq #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .gcd_start(gcd_start), .gcd_data(gcd_data),
        .gcd_done(gcd_done), .gcd_result(gcd_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cycles(res_cycles), .res_err(res_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_op_ready"},   op_ready,   1);
        chk({tag, "_res_valid"},  res_valid,  0);
        chk({tag, "_gcd_start"},  gcd_start,  0);
        chk({tag, "_gcd_data"},   gcd_data,   0);
        chk({tag, "_res_data"},   res_data,   0);
        chk({tag, "_res_cycles"}, res_cycles, 0);
        chk({tag, "_res_err"},    res_err,    0);
    endtask

    function automatic logic [W-1:0] gold_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] t;
        if (a == '0 || b == '0) return a | b;
        while (b != '0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [W-1:0] sub_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        while (a != b) begin
            if (a > b) a = a - b;
            else       b = b - a;
        end
        return a;
    endfunction

    // Behavioural core: captures A then B on start, raises done for one cycle
    // during its core_lat-th busy cycle; spurious done pulses while idle.
    initial begin : core_model
        logic [W-1:0] ca, cb;
        bit got_a, busy;
        int rem;
        got_a = 0; busy = 0; rem = 0; ca = '0; cb = '0;
        forever begin
            @(negedge clk);
            gcd_result = W'($urandom);
            if (!rst_n) begin
                got_a = 0; busy = 0; gcd_done = 1'b0;
            end else if (gcd_start) begin
                gcd_done = 1'b0;
                if (!got_a) begin
                    ca = gcd_data; got_a = 1;
                end else begin
                    cb = gcd_data; got_a = 0; busy = 1; rem = core_lat;
                end
            end else if (busy) begin
                gcd_done = 1'b0;
                if (rem > 0) begin
                    rem--;
                    if (rem == 0) begin
                        gcd_done   = 1'b1;
                        gcd_result = sub_gcd(ca, cb);
                        busy       = 0;
                    end
                end
            end else begin
                gcd_done = ($urandom_range(0, 7) == 0);
            end
        end
    end

    // Transaction-level model advanced once per clock, compared every cycle.
    initial begin : checker_proc
        bit m_ready, m_valid, m_start, m_fly, m_err;
        int m_age, m_wait;
        logic [W-1:0] m_bus, m_res, m_gold;
        logic [15:0] m_cyc;
        m_ready = 1; m_valid = 0; m_start = 0; m_fly = 0; m_err = 0;
        m_age = 0; m_wait = 0; m_bus = '0; m_res = '0; m_gold = '0; m_cyc = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_ready = 1; m_valid = 0; m_start = 0; m_fly = 0; m_err = 0;
                m_bus = '0; m_res = '0; m_cyc = '0;
                chk_reset_outputs("cyc_reset");
            end else begin
                if (m_valid) begin
                    if (res_ready) begin
                        m_valid = 0; m_ready = 1;
                    end
                end else if (m_ready) begin
                    if (op_valid) begin
                        m_ready = 0; m_err = 0;
                        if (op_a == '0 || op_b == '0) begin
                            m_valid = 1; m_res = op_a | op_b; m_cyc = '0;
                        end else begin
                            m_fly = 1; m_age = 0; m_wait = 0; m_start = 1;
                            m_bus = op_a; m_gold = gold_gcd(op_a, op_b);
                        end
                    end
                end else if (m_fly) begin
                    m_age++;
                    if (m_age == 1) begin
                        m_bus = gold_gcd_b_hold(m_bus);
                    end else if (m_age == 2) begin
                        m_start = 0;
                    end else begin
                        m_wait++;
                        if (gcd_done) begin
                            m_fly = 0; m_valid = 1; m_res = m_gold;
                            m_cyc = (m_wait > 65535) ? 16'hFFFF : 16'(m_wait);
`ifdef GCD_TIMEOUT_EN
                        end else if (m_wait == TO) begin
                            m_fly = 0; m_valid = 1; m_res = '0; m_cyc = 16'(TO); m_err = 1;
`endif
                        end
                    end
                end
                chk("cyc_op_ready",  op_ready,  m_ready);
                chk("cyc_res_valid", res_valid, m_valid);
                chk("cyc_gcd_start", gcd_start, m_start);
                chk("cyc_res_err",   res_err,   m_err);
                if (m_fly) chk("cyc_gcd_data", gcd_data, m_bus);
                if (m_valid) begin
                    chk("cyc_res_data",   res_data,   m_res);
                    chk("cyc_res_cycles", res_cycles, m_cyc);
                end
            end
        end
    end

    // Operand B as last offered on the bus at accept time.
    logic [W-1:0] b_at_accept = '0;
    always @(posedge clk) if (op_valid && op_ready) b_at_accept <= op_b;
    function automatic logic [W-1:0] gold_gcd_b_hold(input logic [W-1:0] unused_prev);
        return b_at_accept;
    endfunction

    // One full transaction; returns the observed result and latency (in
    // cycles from the accept edge to the first res_valid cycle).
    task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                       input int hold, output logic [W-1:0] rd, output logic [15:0] rc,
                       output logic re, output int k);
        int g;
        bit nz;
        nz = (a != '0) && (b != '0);
        @(negedge clk);
        op_a = a; op_b = b; op_valid = 1'b1; core_lat = lat; res_ready = 1'b0;
        g = 0;
        while (!op_ready && g < 50) begin @(negedge clk); g++; end
        chk("accept_wait", g < 50, 1);
        @(negedge clk);
        op_valid = 1'b0;
        k = 0;
        if (nz) begin
            chk("load_a_start", gcd_start, 1);
            chk("load_a_data",  gcd_data,  a);
        end else begin
            chk("bypass_no_start", gcd_start, 0);
        end
        while (!res_valid && k < 300) begin
            @(negedge clk);
            k++;
            if (k == 1 && nz) begin
                chk("load_b_start", gcd_start, 1);
                chk("load_b_data",  gcd_data,  b);
            end
        end
        chk("resp_wait", res_valid, 1);
        rd = res_data; rc = res_cycles; re = res_err;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_op_ready",  op_ready,  0);
            chk("hold_res_valid", res_valid, 1);
            chk("hold_res_data",  res_data,  rd);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("after_hs_op_ready", op_ready, 1);
    endtask

    initial begin : stim
        logic [W-1:0] rd, a, b;
        logic [15:0]  rc;
        logic         re;
        int k, g, lat;

        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;

        // Main function with hand-computed results
        txn(16'd90, 16'd81, 7, 0, rd, rc, re, k);
        chk("t1_res_data", rd, 9);
        chk("t1_res_cycles", rc, 7);
        chk("t1_latency", k, 9);
        chk("t1_res_err", re, 0);

        // Zero bypass
        txn(16'd0, 16'd35, 3, 0, rd, rc, re, k);
        chk("t2_res_data", rd, 35);
        chk("t2_res_cycles", rc, 0);
        chk("t2_latency", k, 0);
        txn(16'd0, 16'd0, 3, 0, rd, rc, re, k);
        chk("t2b_res_data", rd, 0);

        // Back-pressure on the response
        txn(16'd48, 16'd18, 5, 10, rd, rc, re, k);
        chk("t3_res_data", rd, 6);
        chk("t3_res_cycles", rc, 5);

        // Offer while busy is ignored, then taken after the handshake
        @(negedge clk);
        op_a = 16'd90; op_b = 16'd81; op_valid = 1'b1; core_lat = 6; res_ready = 1'b1;
        @(negedge clk);
        op_a = 16'd12; op_b = 16'd8;
        g = 0;
        while (!res_valid && g < 100) begin @(negedge clk); g++; end
        chk("t4_first_res", res_data, 9);
        @(negedge clk);
        chk("t4_back_idle", op_ready, 1);
        @(negedge clk);
        op_valid = 1'b0;
        g = 0;
        while (!res_valid && g < 100) begin @(negedge clk); g++; end
        chk("t4_second_res", res_data, 4);
        @(negedge clk);
        res_ready = 1'b0;

        // Reset mid-WAIT aborts the transaction
        @(negedge clk);
        op_a = 16'd90; op_b = 16'd81; op_valid = 1'b1; core_lat = 30;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midwait_reset");
        @(negedge clk);
        rst_n = 1'b1;
        txn(16'd21, 16'd14, 4, 0, rd, rc, re, k);
        chk("t5_res_data", rd, 7);

`ifdef GCD_TIMEOUT_EN
        txn(16'd5, 16'd3, 0, 0, rd, rc, re, k);
        chk("t6_err", re, 1);
        chk("t6_res_data", rd, 0);
        chk("t6_res_cycles", rc, 16);
        chk("t6_latency", k, 18);
        txn(16'd90, 16'd81, 4, 0, rd, rc, re, k);
        chk("t6b_res_data", rd, 9);
        chk("t6b_err", re, 0);
`else
        // Long compute, well beyond any small watchdog
        txn(16'd1071, 16'd462, 40, 0, rd, rc, re, k);
        chk("long_res_data", rd, 21);
        chk("long_res_cycles", rc, 40);
`endif

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 300));
            lat = $urandom_range(1, 12);
            txn(a, b, lat, $urandom_range(0, 3), rd, rc, re, k);
            chk("rand_res_data", rd, gold_gcd(a, b));
            chk("rand_res_cycles", rc, (a == '0 || b == '0) ? 0 : lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : global_guard
        #2000000;
        n_fail++;
        $display("FAIL global_timeout: got %0d, expected 0 (t=%0t)", 1, $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
